multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have ports: opcode  input  6  instr[31:26]; funct  input  6  instr[5:0]; zero  input  1  ALU zero flag.
REQ-004 SHALL have port: mem_ready  input  1  memory handshake; access completes in the cycle it is 1.
REQ-005 SHALL have ports: iord, mem_read, mem_write, ir_write  output  1 each  memory/IR control.
REQ-006 SHALL have ports: reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  register-file/ALU mux control.
REQ-007 SHALL have ports: alu_src_b  output  2  00 B, 01 const 4, 10 sign_ext, 11 sign_ext<<2; alu_op  output  2  00 add, 01 sub, 10 funct, 11 opcode-logical.
REQ-008 SHALL have ports: pc_src  output  2  00 ALU, 01 ALUOut, 10 jump target; pc_en  output  1  PC load enable; ext_zero  output  1  1 = zero-extend immediate.
REQ-009 SHALL have ports: state  output  4  current state encoding; illegal_op  output  1  one-cycle flag for unsupported opcode.

Function
REQ-010 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, IMMEXEC=9, IMMWB=10, JUMP=11; codes 12-15 unreachable, go to FETCH.
REQ-011 SHALL decode opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, ANDI 001100, ORI 001101, J 000010.
REQ-012 FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00; ir_write=pc_en=mem_ready; stay while mem_ready=0, else DECODE.
REQ-013 DECODE: alu_src_a=0, alu_src_b=11, alu_op=00; next LW/SW->MEMADR, R->EXEC, BEQ->BRANCH, ADDI/ANDI/ORI->IMMEXEC, J->JUMP, else FETCH with illegal_op=1 this cycle.
REQ-014 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00, ext_zero=0; next LW->MEMRD, SW->MEMWR.
REQ-015 MEMRD: iord=1, mem_read=1; stay while mem_ready=0, else MEMWB.
REQ-016 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; next FETCH.
REQ-017 MEMWR: iord=1, mem_write=1; stay while mem_ready=0, else FETCH.
REQ-018 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next ALUWB. ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; next FETCH.
REQ-019 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_en=zero; next FETCH.
REQ-020 IMMEXEC: alu_src_a=1, alu_src_b=10; ADDI alu_op=00, ext_zero=0; ANDI/ORI alu_op=11, ext_zero=1; next IMMWB.
REQ-021 IMMWB: reg_dst=0, mem_to_reg=0, reg_write=1, ext_zero held as in IMMEXEC; next FETCH.
REQ-022 JUMP: pc_src=10, pc_en=1; next FETCH.
REQ-023 Any output not listed for a state SHALL be 0; mem_read and mem_write SHALL never both be 1.
REQ-024 opcode/funct SHALL be sampled only in DECODE and states after it (IR stable); changes during FETCH SHALL not affect sequencing.
REQ-025 Unhandshaked cycle counts (mem_ready=1): LW 5, SW 4, R 4, ADDI/ANDI/ORI 4, BEQ 3, J 3; each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.

Reset
REQ-026 When rst_n=0 at a rising clk edge, state SHALL become FETCH regardless of current state, including mid-access stalls.
REQ-027 After reset, outputs SHALL equal FETCH values: mem_read=1, alu_src_b=01, all other outputs 0 except ir_write=pc_en=mem_ready; illegal_op=0.
REQ-028 No write strobe (mem_write, reg_write) SHALL assert in the cycle following a reset edge.

Verification
REQ-029 Reset, opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4.
REQ-030 BEQ opcode=000100, zero=1 -> states 0,1,8,0 with pc_en=1, pc_src=01 in state 8; repeat with zero=0 -> pc_en=0 in state 8.
REQ-031 SW with mem_ready=0 for 3 cycles in MEMWR -> state 5 held 4 cycles, mem_write=1 each, then FETCH.
REQ-032 opcode=111111 -> states 0,1,0; illegal_op=1 exactly in DECODE cycle; no reg_write/mem_write asserted.
REQ-033 ORI opcode=001101 -> states 0,1,9,10,0; alu_op=11, ext_zero=1 in states 9 and 10.
REQ-034 rst_n=0 for one edge while in MEMRD with mem_ready=0 -> next state FETCH, reg_write never asserted.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: Moore sequencer producing datapath mux,
// memory and register-file strobes, with a stall handshake on memory accesses.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ext_zero,
  output logic [3:0] state,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEXEC = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_e state_q, state_d;

  // funct is consumed by the ALU decoder, not by the sequencer.
  logic unused_funct;
  assign unused_funct = ^funct;

  logic is_logical_imm;
  assign is_logical_imm = (opcode == OP_ANDI) || (opcode == OP_ORI);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d    = FETCH;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    pc_en      = 1'b0;
    ext_zero   = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        state_d   = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:               state_d = MEMADR;
          OP_R:                       state_d = EXEC;
          OP_BEQ:                     state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI:   state_d = IMMEXEC;
          OP_J:                       state_d = JUMP;
          default: begin
            state_d    = FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = mem_ready ? FETCH : MEMWR;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_en     = zero;
      end
      IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = is_logical_imm ? 2'b11 : 2'b00;
        ext_zero  = is_logical_imm;
        state_d   = IMMWB;
      end
      IMMWB: begin
        reg_write = 1'b1;
        ext_zero  = is_logical_imm;
      end
      JUMP: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instruction sequences
// push expected state/outputs; a negedge monitor pops and compares.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       pc_en, ext_zero, illegal_op;
  logic [3:0] state;

  multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .pc_en(pc_en),
    .ext_zero(ext_zero), .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Output vector order:
  // iord mem_read mem_write ir_write | reg_dst mem_to_reg reg_write alu_src_a |
  // alu_src_b | alu_op | pc_src | pc_en ext_zero | illegal_op
  localparam logic [16:0] O_FETCH    = 17'b0101_0000_01_00_00_10_0;
  localparam logic [16:0] O_FETCH_W  = 17'b0100_0000_01_00_00_00_0;
  localparam logic [16:0] O_DECODE   = 17'b0000_0000_11_00_00_00_0;
  localparam logic [16:0] O_DEC_ILL  = 17'b0000_0000_11_00_00_00_1;
  localparam logic [16:0] O_MEMADR   = 17'b0000_0001_10_00_00_00_0;
  localparam logic [16:0] O_MEMRD    = 17'b1100_0000_00_00_00_00_0;
  localparam logic [16:0] O_MEMWB    = 17'b0000_0110_00_00_00_00_0;
  localparam logic [16:0] O_MEMWR    = 17'b1010_0000_00_00_00_00_0;
  localparam logic [16:0] O_EXEC     = 17'b0000_0001_00_10_00_00_0;
  localparam logic [16:0] O_ALUWB    = 17'b0000_1010_00_00_00_00_0;
  localparam logic [16:0] O_BR_T     = 17'b0000_0001_00_01_01_10_0;
  localparam logic [16:0] O_BR_NT    = 17'b0000_0001_00_01_01_00_0;
  localparam logic [16:0] O_IMM_ADD  = 17'b0000_0001_10_00_00_00_0;
  localparam logic [16:0] O_IMM_LOG  = 17'b0000_0001_10_11_00_01_0;
  localparam logic [16:0] O_IWB_ADD  = 17'b0000_0010_00_00_00_00_0;
  localparam logic [16:0] O_IWB_LOG  = 17'b0000_0010_00_00_00_01_0;
  localparam logic [16:0] O_JUMP     = 17'b0000_0000_00_00_10_10_0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct {
    string       name;
    logic [3:0]  st;
    logic [16:0] o;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  logic [16:0] out_vec;
  assign out_vec = {iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en,
                    ext_zero, illegal_op};

  // Called at posedge+1: drive this cycle's inputs, record what the DUT must show.
  task automatic step(input string name, input logic [5:0] op, input logic rdy,
                      input logic z, input logic rn, input logic [3:0] st,
                      input logic [16:0] o);
    exp_t e;
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    rst_n     = rn;
    e.name = name;
    e.st   = st;
    e.o    = o;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (state !== e.st) begin
        bad++;
        $display("FAIL %s state: got %0d want %0d", e.name, state, e.st);
      end
      total++;
      if (out_vec !== e.o) begin
        bad++;
        $display("FAIL %s outputs: got %b want %b", e.name, out_vec, e.o);
      end
      total++;
      if (mem_read && mem_write) begin
        bad++;
        $display("FAIL %s rd_wr_excl: got rd=%b wr=%b want not both", e.name,
                 mem_read, mem_write);
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = OP_BAD; funct = 6'b100000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // LW, with a garbage opcode during FETCH that must not affect sequencing
    step("lw_f",   OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("lw_d",   OP_LW,  1, 0, 1, 4'd1, O_DECODE);
    step("lw_a",   OP_LW,  1, 0, 1, 4'd2, O_MEMADR);
    step("lw_r",   OP_LW,  1, 0, 1, 4'd3, O_MEMRD);
    step("lw_wb",  OP_LW,  1, 0, 1, 4'd4, O_MEMWB);
    // BEQ taken / not taken
    step("beqt_f", OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("beqt_d", OP_BEQ, 1, 1, 1, 4'd1, O_DECODE);
    step("beqt_b", OP_BEQ, 1, 1, 1, 4'd8, O_BR_T);
    step("beqn_f", OP_BAD, 1, 1, 1, 4'd0, O_FETCH);
    step("beqn_d", OP_BEQ, 1, 0, 1, 4'd1, O_DECODE);
    step("beqn_b", OP_BEQ, 1, 0, 1, 4'd8, O_BR_NT);
    // SW with three memory stalls
    step("sw_f",   OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("sw_d",   OP_SW,  1, 0, 1, 4'd1, O_DECODE);
    step("sw_a",   OP_SW,  1, 0, 1, 4'd2, O_MEMADR);
    step("sw_w0",  OP_SW,  0, 0, 1, 4'd5, O_MEMWR);
    step("sw_w1",  OP_SW,  0, 0, 1, 4'd5, O_MEMWR);
    step("sw_w2",  OP_SW,  0, 0, 1, 4'd5, O_MEMWR);
    step("sw_w3",  OP_SW,  1, 0, 1, 4'd5, O_MEMWR);
    // Illegal opcode
    step("ill_f",  OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("ill_d",  OP_BAD, 1, 0, 1, 4'd1, O_DEC_ILL);
    // ORI (logical immediate) and ADDI
    step("ori_f",  OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("ori_d",  OP_ORI, 1, 0, 1, 4'd1, O_DECODE);
    step("ori_x",  OP_ORI, 1, 0, 1, 4'd9, O_IMM_LOG);
    step("ori_wb", OP_ORI, 1, 0, 1, 4'd10, O_IWB_LOG);
    step("adi_f",  OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("adi_d",  OP_ADDI, 1, 0, 1, 4'd1, O_DECODE);
    step("adi_x",  OP_ADDI, 1, 0, 1, 4'd9, O_IMM_ADD);
    step("adi_wb", OP_ADDI, 1, 0, 1, 4'd10, O_IWB_ADD);
    // R-type, with two FETCH stalls first
    step("r_fw0",  OP_BAD, 0, 0, 1, 4'd0, O_FETCH_W);
    step("r_fw1",  OP_R,   0, 0, 1, 4'd0, O_FETCH_W);
    step("r_f",    OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("r_d",    OP_R,   1, 0, 1, 4'd1, O_DECODE);
    step("r_x",    OP_R,   1, 0, 1, 4'd6, O_EXEC);
    step("r_wb",   OP_R,   1, 0, 1, 4'd7, O_ALUWB);
    // Jump
    step("j_f",    OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("j_d",    OP_J,   1, 0, 1, 4'd1, O_DECODE);
    step("j_j",    OP_J,   1, 0, 1, 4'd11, O_JUMP);
    // Reset while stalled in MEMRD: next cycle is FETCH, no MEMWB write
    step("rst_f",  OP_BAD, 1, 0, 1, 4'd0, O_FETCH);
    step("rst_d",  OP_LW,  1, 0, 1, 4'd1, O_DECODE);
    step("rst_a",  OP_LW,  1, 0, 1, 4'd2, O_MEMADR);
    step("rst_r0", OP_LW,  0, 0, 1, 4'd3, O_MEMRD);
    step("rst_r1", OP_LW,  0, 0, 0, 4'd3, O_MEMRD);
    step("rst_f2", OP_LW,  1, 0, 1, 4'd0, O_FETCH);
    step("rst_d2", OP_J,   1, 0, 1, 4'd1, O_DECODE);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
